// File: rtl/gold_pkg.sv
// gold_pkg: bag state encoding and playfield geometry shared with the terrain stage
package gold_pkg;
   localparam int TILE = 32;
   localparam logic [10:0] BOARD_Y_DEFAULT = 11'd160;
   typedef enum logic [2:0] {REST, WOBBLE, FALL, BROKEN, GONE} gold_state_t;
endpackage

// File: rtl/gold_bag_ctrl_if.sv
// gold_bag_ctrl_if: frame strobe, terrain/player inputs and bag position/status outputs
interface gold_bag_ctrl_if;
   logic        startOfFrame;
   logic        can_fall;
   logic        player_hit;
   logic [10:0] topLeftX;
   logic [10:0] topLeftY;
   logic        visible;
   logic        broken;
   logic        gold_collected;
   logic        player_crushed;
   modport master (output startOfFrame, can_fall, player_hit,
                   input topLeftX, topLeftY, visible, broken, gold_collected, player_crushed);
   modport slave (input startOfFrame, can_fall, player_hit,
                  output topLeftX, topLeftY, visible, broken, gold_collected, player_crushed);
endinterface

// File: rtl/gold_bag_ctrl.sv
// gold_bag_ctrl: per-bag rest/wobble/fall/break FSM, updated once per video frame
module gold_bag_ctrl
   import gold_pkg::*;
#(
   parameter logic [10:0] INIT_X        = 11'd96,
   parameter logic [10:0] INIT_Y        = 11'd192,
   parameter logic [10:0] BOARD_Y       = BOARD_Y_DEFAULT,
   parameter logic [10:0] BOTTOM_Y      = 11'd448,
   parameter int          FALL_SPEED    = 4,
   parameter int          WOBBLE_FRAMES = 16,
   parameter int          BREAK_PX      = 64
) (
   input logic             clk,
   input logic             reset,
   gold_bag_ctrl_if.slave  bus
);
   gold_state_t state, nState;
   logic [7:0]  wobCnt, nWob;
   logic [10:0] posY, nY, fallPx, nFall;
   logic [11:0] stepY, stepFall;
   logic        aligned, landing, crush, collect;
   assign bus.topLeftY = posY;
   always_comb begin
      stepY = {1'b0, posY} + 12'(FALL_SPEED);
      stepFall = {1'b0, fallPx} + 12'(FALL_SPEED);
      aligned = ((posY - BOARD_Y) & 11'(TILE - 1)) == '0;
      landing = aligned && (!bus.can_fall || posY >= BOTTOM_Y);
      nState = state;
      nWob = wobCnt;
      nY = posY;
      nFall = fallPx;
      crush = 1'b0;
      collect = 1'b0;
      if (bus.startOfFrame) begin
         case (state)
            REST: begin
               if (bus.can_fall) begin
                  nState = WOBBLE;
                  nWob = '0;
               end
            end
            WOBBLE: begin
               if (!bus.can_fall) nState = REST;
               else if (wobCnt == 8'(WOBBLE_FRAMES - 1)) begin
                  nState = FALL;
                  nFall = '0;
               end else nWob = wobCnt + 8'd1;
            end
            FALL: begin
               crush = bus.player_hit;
               if (landing) nState = (fallPx >= 11'(BREAK_PX)) ? BROKEN : REST;
               else begin
                  nY = (stepY >= {1'b0, BOTTOM_Y}) ? BOTTOM_Y : stepY[10:0];
                  nFall = stepFall[11] ? '1 : stepFall[10:0];
               end
            end
            BROKEN: begin
               // collection beats any terrain verdict: a broken bag never falls again
               if (bus.player_hit) begin
                  nState = GONE;
                  collect = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= REST;
         wobCnt <= '0;
         fallPx <= '0;
         posY <= INIT_Y;
         bus.topLeftX <= INIT_X;
         bus.visible <= 1'b1;
         bus.broken <= 1'b0;
         bus.gold_collected <= 1'b0;
         bus.player_crushed <= 1'b0;
      end else begin
         state <= nState;
         wobCnt <= nWob;
         fallPx <= nFall;
         posY <= nY;
         bus.topLeftX <= (nState == WOBBLE && nWob[2]) ? INIT_X + 11'd2 : INIT_X;
         bus.visible <= nState != GONE;
         bus.broken <= nState == BROKEN;
         bus.gold_collected <= collect;
         bus.player_crushed <= crush;
      end
   end
endmodule

// File: tb/tb_gold_bag_ctrl.sv
// tb_gold_bag_ctrl: directed frame-by-frame vectors against hand-computed bag positions
module tb_gold_bag_ctrl;
   logic clk = 1'b0;
   logic reset;
   int nVec = 0;
   int nMiss = 0;
   gold_bag_ctrl_if bus();
   gold_bag_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one frame: strobe for one cycle, then scramble inputs in the gap to prove they are ignored
   task automatic frame(input logic cf, input logic ph);
      @(negedge clk);
      bus.startOfFrame = 1'b1;
      bus.can_fall = cf;
      bus.player_hit = ph;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      bus.can_fall = ~cf;
      bus.player_hit = 1'b1;
   endtask

   task automatic chkHome(input string tag);
      chk({tag, ".x"}, 32'(bus.topLeftX), 96);
      chk({tag, ".y"}, 32'(bus.topLeftY), 192);
      chk({tag, ".vis"}, 32'(bus.visible), 1);
      chk({tag, ".brk"}, 32'(bus.broken), 0);
      chk({tag, ".gold"}, 32'(bus.gold_collected), 0);
      chk({tag, ".crush"}, 32'(bus.player_crushed), 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chkHome("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic enterFall();
      frame(1'b1, 1'b0);
      chk("wob0.x", 32'(bus.topLeftX), 96);
      for (int i = 0; i < 15; i++) begin
         frame(1'b1, 1'b0);
         chk("wob.x", 32'(bus.topLeftX), ((i + 1) & 4) != 0 ? 98 : 96);
         chk("wob.y", 32'(bus.topLeftY), 192);
      end
      frame(1'b1, 1'b0);
      chk("fall0.x", 32'(bus.topLeftX), 96);
      chk("fall0.y", 32'(bus.topLeftY), 192);
   endtask

   initial begin
      reset = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.can_fall = 1'b0;
      bus.player_hit = 1'b0;
      doReset();
      for (int i = 0; i < 20; i++) begin
         frame(1'b0, 1'b0);
         chkHome("rest20");
      end
      enterFall();
      for (int k = 1; k <= 8; k++) begin
         frame(1'b1, 1'b0);
         chk("short.y", 32'(bus.topLeftY), 32'(192 + 4 * k));
         chk("short.x", 32'(bus.topLeftX), 96);
      end
      frame(1'b0, 1'b0);
      chk("land32.y", 32'(bus.topLeftY), 224);
      chk("land32.brk", 32'(bus.broken), 0);
      chk("land32.vis", 32'(bus.visible), 1);
      frame(1'b0, 1'b0);
      chk("rest224.y", 32'(bus.topLeftY), 224);

      doReset();
      enterFall();
      for (int k = 1; k <= 16; k++) begin
         frame(1'b1, 1'b0);
         chk("brk.y", 32'(bus.topLeftY), 32'(192 + 4 * k));
      end
      frame(1'b0, 1'b0);
      chk("land64.brk", 32'(bus.broken), 1);
      chk("land64.y", 32'(bus.topLeftY), 256);
      frame(1'b1, 1'b0);
      chk("brkstay.brk", 32'(bus.broken), 1);
      chk("brkstay.y", 32'(bus.topLeftY), 256);
      frame(1'b1, 1'b1);
      chk("collect.gold", 32'(bus.gold_collected), 1);
      chk("collect.vis", 32'(bus.visible), 0);
      chk("collect.brk", 32'(bus.broken), 0);
      @(negedge clk);
      chk("collect.pulse1", 32'(bus.gold_collected), 0);
      frame(1'b1, 1'b1);
      chk("gone.gold", 32'(bus.gold_collected), 0);
      chk("gone.vis", 32'(bus.visible), 0);
      chk("gone.y", 32'(bus.topLeftY), 256);

      doReset();
      enterFall();
      for (int k = 1; k <= 64; k++) begin
         frame(1'b1, k == 3 || k == 4);
         chk("deep.y", 32'(bus.topLeftY), 32'(192 + 4 * k));
         chk("deep.crush", 32'(bus.player_crushed), (k == 3 || k == 4) ? 1 : 0);
         if (k == 3) begin
            @(negedge clk);
            chk("crush.pulse1", 32'(bus.player_crushed), 0);
         end
      end
      frame(1'b1, 1'b0);
      chk("bottom.y", 32'(bus.topLeftY), 448);
      chk("bottom.brk", 32'(bus.broken), 1);
      frame(1'b1, 1'b0);
      chk("bottom2.y", 32'(bus.topLeftY), 448);

      doReset();
      frame(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
      chk("abort.x", 32'(bus.topLeftX), 96);
      chk("abort.y", 32'(bus.topLeftY), 192);
      enterFall();
      frame(1'b1, 1'b0);
      chk("refall.y", 32'(bus.topLeftY), 196);

      doReset();
      enterFall();
      for (int k = 1; k <= 10; k++) frame(1'b1, 1'b0);
      chk("midfall.y", 32'(bus.topLeftY), 232);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chkHome("asyncrst");
      @(negedge clk);
      reset = 1'b0;
      frame(1'b0, 1'b0);
      chkHome("postrst");

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end
endmodule

// File: doc/gold_bag_ctrl.md
# gold_bag_ctrl

Per-bag motion controller for a gold bag on the playfield. Each frame it samples the `can_fall` verdict that the terrain stage computes for the bag's current position. It runs the bag through rest, wobble, fall and break/collect states, and drives the bag's top-left coordinates back into the terrain stage and the draw path. One instance exists per bag.

## Interface
- `INIT_X`, 11'd96: reset column of the bag's top-left (pixels, tile-aligned).
- `INIT_Y`, 11'd192: reset row of the bag's top-left (pixels, tile-aligned).
- `BOARD_Y`, 11'd160: board top row; tile grid origin in Y.
- `BOTTOM_Y`, 11'd448: lowest legal top-left Y (`BOARD_Y` + 320 − `TILE`).
- `TILE`, 32: tile size in pixels; power of two.
- `FALL_SPEED`, 4: pixels per frame while falling; must divide `TILE`.
- `WOBBLE_FRAMES`, 16: frames of wobble before falling.
- `BREAK_PX`, 64: fall distance at or above which the bag breaks on landing.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle pulse per video frame; all state updates occur only on this pulse.
- `can_fall`  in  1  terrain verdict: the tile below the bag is empty.
- `player_hit`  in  1  player/bag sprite overlap, level-valid at `startOfFrame`.
- `topLeftX`  out  11  displayed bag X, including wobble offset.
- `topLeftY`  out  11  bag Y, fed to the terrain query.
- `visible`  out  1  bag is drawn.
- `broken`  out  1  bag is in broken (collectible) form.
- `gold_collected`  out  1  one-cycle pulse when the player collects a broken bag.
- `player_crushed`  out  1  one-cycle pulse when a falling bag hits the player.

## Operation
- States: `REST`, `WOBBLE`, `FALL`, `BROKEN`, `GONE`. Evaluated only on `startOfFrame`.
- `REST`:
  - `can_fall`=1 → `WOBBLE`; clear `wob_cnt`.
  - Otherwise stay.
- `WOBBLE`:
  - `can_fall`=0 → `REST`. This takes priority.
  - Otherwise `wob_cnt`++.
  - When `wob_cnt` = `WOBBLE_FRAMES`−1 → `FALL`; clear `fall_px`.
- `FALL`:
  - `player_hit`=1 → pulse `player_crushed`. Motion continues.
  - Landing: Y is tile-aligned ((Y−`BOARD_Y`) mod `TILE` = 0) and (`can_fall`=0 or Y ≥ `BOTTOM_Y`).
    - On landing with `fall_px` ≥ `BREAK_PX` → `BROKEN`.
    - On landing with `fall_px` < `BREAK_PX` → `REST`.
  - Otherwise Y += `FALL_SPEED` and `fall_px` += `FALL_SPEED`.
  - `fall_px` is 11 bits and saturates at 2047.
  - Y never exceeds `BOTTOM_Y`; clamp.
- `BROKEN`: `broken`=1. `player_hit`=1 → `GONE` and pulse `gold_collected`.
- `GONE`: `visible`=0 and `broken`=0. This state is terminal until reset.
- `topLeftX` = base X + 2 when in `WOBBLE` and `wob_cnt[2]`=1; otherwise base X. Base X never changes.
- Terrain queries use `topLeftY` only. X wobble never exceeds 2 px, so the queried column is unchanged.

## Timing
- Reset values:
  - State `REST`.
  - `topLeftX`=`INIT_X`, `topLeftY`=`INIT_Y`.
  - `visible`=1, `broken`=0.
  - Pulses 0.
  - Counters 0.
- Reset takes effect immediately, including mid-fall; the bag returns to `INIT_X`/`INIT_Y` on reset.
- All outputs are registered. They change in the cycle after `startOfFrame`, at latency 1.
- `can_fall` and `player_hit` are sampled in the `startOfFrame` cycle only. Values between frames are ignored.
- Pulses last exactly one `clk` cycle. At most one of each pulse fires per frame.
- If `can_fall` and `player_hit` both assert in `BROKEN`, collection wins; the bag does not fall again.
- Bottom row: in `FALL` at Y=`BOTTOM_Y`, the bag lands even with `can_fall`=1.

## Structure
- `gold_pkg`:
  - `gold_state_t` enum.
  - Shared `TILE` constant.
  - `BOARD_Y` default, shared with the terrain stage.
- No sub-module. One FSM plus two counters (`wob_cnt`, `fall_px`) and the Y register.

## Test plan
- Reset, `can_fall`=0 for 20 frames → `topLeftY`=192 and `REST` throughout; `topLeftX` stays 96.
- `can_fall`=1 steady → 16 wobble frames with X toggling 96/98; Y then steps +4 per frame. Drop `can_fall` at Y=224 → `REST` (`fall_px`=32 < 64), `broken`=0.
- `can_fall`=1 until Y=256 (`fall_px`=64) → `BROKEN`. Then `player_hit` → one-cycle `gold_collected`, `visible`=0, and the bag is ignored thereafter.
- `can_fall` held 1 → Y clamps at 448 and the bag lands `BROKEN` at the bottom row.
- `can_fall` drops at wobble frame 10 → `REST`, X=96. Re-assert → the wobble count restarts from 0.
- Assert `player_hit` during `FALL` → `player_crushed` pulses once per frame hit. Assert `reset` mid-fall → immediate Y=192, `REST`.
